// File: rtl/usb4_lane_encoder.sv
// usb4_lane_encoder: N-lane symbol gatherer/encoder for the USB4 transmit path.
// Bytes arrive one per lane per accepted cycle and are packed LSB-first into a
// per-lane payload. A complete symbol is then moved into the output register
// with the sync header for its mode:
//   mode 2 -> 64b/66b
//   mode 1 -> 128b/132b
//   mode 0 -> single-byte bypass
// Handshakes: a transfer happens on an edge where valid && ready are both high.
// Valid never waits on ready. Data is held stable while valid && !ready.
module usb4_lane_encoder #(
  parameter int NUM_LANES = 2,
  parameter int SYM_W     = 132
) (
  input  logic                       enc_clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [1:0]                 gen_speed,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_LANES*8-1:0]     in_data,
  input  logic                       in_ctrl,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_LANES*SYM_W-1:0] out_data,
  output logic                       out_ctrl,
  output logic [1:0]                 out_mode,
  output logic                       sym_abort,
  output logic [15:0]                sym_cnt
);

  localparam logic [1:0] MODE_BYP = 2'd0;
  localparam logic [1:0] MODE_G3  = 2'd1;
  localparam logic [1:0] MODE_G2  = 2'd2;
  localparam logic [1:0] MODE_RSV = 2'd3;

  logic [4:0]   count;
  logic [1:0]   mode_reg;
  logic         ctrl_reg;
  logic         run;
  logic [127:0] payload [NUM_LANES];

  logic [4:0]   sym_len;
  logic         full;
  logic         free;
  logic         abort_cond;
  logic         accept;
  logic         transfer;
  logic         handoff;
  logic [3:0]   slot;
  logic [NUM_LANES*SYM_W-1:0] enc_word;

  // Symbol length of the gather in progress and the handshake decisions.
  always_comb begin
    case (mode_reg)
      MODE_G2: sym_len = 5'd8;
      MODE_G3: sym_len = 5'd16;
      default: sym_len = 5'd1;
    endcase
    full       = (count == sym_len);
    free       = !out_valid || out_ready;
    // A partial symbol is dropped when the speed no longer matches the one
    // it was started under. A full gather is not dropped: it still transfers.
    abort_cond = run && enable && (count != 5'd0) && !full && (gen_speed != mode_reg);
    in_ready   = run && enable && (gen_speed != MODE_RSV) && !abort_cond && (!full || free);
    accept     = in_valid && in_ready;
    transfer   = run && enable && full && free;
    handoff    = run && enable && out_valid && out_ready;
    slot       = transfer ? 4'd0 : count[3:0];
  end

  // Build the per-lane output words from the gathered payload.
  always_comb begin
    enc_word = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      case (mode_reg)
        MODE_G2: begin
          enc_word[SYM_W*k+2 +: 64] = payload[k][63:0];
          enc_word[SYM_W*k +: 2]    = ctrl_reg ? 2'b10 : 2'b01;
        end
        MODE_G3: begin
          enc_word[SYM_W*k+4 +: 128] = payload[k];
          enc_word[SYM_W*k +: 4]     = ctrl_reg ? 4'b1010 : 4'b0101;
        end
        default: begin
          enc_word[SYM_W*k +: 8] = payload[k][7:0];
        end
      endcase
    end
  end

  // Payload storage. It needs no reset because the byte count qualifies it.
  always_ff @(posedge enc_clk) begin
    if (accept) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        payload[k][{slot, 3'b000} +: 8] <= in_data[8*k +: 8];
      end
    end
  end

  // Control state: gather count, captured mode/ctrl, output register, counters.
  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      run       <= 1'b0;
      count     <= 5'd0;
      mode_reg  <= MODE_BYP;
      ctrl_reg  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= 1'b0;
      out_mode  <= 2'd0;
      sym_abort <= 1'b0;
      sym_cnt   <= 16'd0;
    end else begin
      run <= 1'b1;
      if (!enable) begin
        count     <= 5'd0;
        out_valid <= 1'b0;
        sym_abort <= 1'b0;
      end else begin
        sym_abort <= abort_cond;
        if (handoff) sym_cnt <= sym_cnt + 16'd1;

        if (transfer) begin
          out_data  <= enc_word;
          out_ctrl  <= ctrl_reg && (mode_reg != MODE_BYP);
          out_mode  <= mode_reg;
          out_valid <= 1'b1;
        end else if (handoff) begin
          out_valid <= 1'b0;
        end

        if (abort_cond) begin
          count <= 5'd0;
        end else if (accept) begin
          count <= transfer ? 5'd1 : count + 5'd1;
          if (transfer || count == 5'd0) begin
            mode_reg <= gen_speed;
            ctrl_reg <= in_ctrl;
          end
        end else if (transfer) begin
          count <= 5'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_usb4_lane_encoder.sv
// Testbench for usb4_lane_encoder.
// Uses a symbol-level reference model that feeds an expected queue, plus a
// monitor that compares every handoff against that queue.
`timescale 1ns/1ps
module tb_usb4_lane_encoder;

  localparam int NUM_LANES = 2;
  localparam int SYM_W     = 132;
  localparam int DW        = NUM_LANES*SYM_W;
  localparam int W         = DW + 3;

  logic                   enc_clk;
  logic                   rst;
  logic                   enable;
  logic [1:0]             gen_speed;
  logic                   in_valid;
  logic                   in_ready;
  logic [NUM_LANES*8-1:0] in_data;
  logic                   in_ctrl;
  logic                   out_valid;
  logic                   out_ready;
  logic [DW-1:0]          out_data;
  logic                   out_ctrl;
  logic [1:0]             out_mode;
  logic                   sym_abort;
  logic [15:0]            sym_cnt;

  usb4_lane_encoder #(.NUM_LANES(NUM_LANES), .SYM_W(SYM_W)) dut (
    .enc_clk   (enc_clk),
    .rst       (rst),
    .enable    (enable),
    .gen_speed (gen_speed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .out_mode  (out_mode),
    .sym_abort (sym_abort),
    .sym_cnt   (sym_cnt)
  );

  // Clock and reset block
  initial enc_clk = 1'b0;
  always #5 enc_clk = ~enc_clk;

  int checks      = 0;
  int errors      = 0;
  int exp_sym_cnt = 0;
  int exp_aborts  = 0;
  int seen_aborts = 0;
  bit rand_ready  = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  mon_got;
  logic [DW-1:0] snap;

  // Reference model state: the partial symbol being gathered
  int         part_len  = 0;
  int         part_mode = 0;
  bit         part_ctrl = 0;
  logic [7:0] part_bytes [NUM_LANES][16];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int sym_len_of(input int mode);
    return (mode == 2) ? 8 : (mode == 1) ? 16 : 1;
  endfunction

  function automatic void model_abort();
    if (part_len > 0) begin
      part_len = 0;
      exp_aborts++;
    end
  endfunction

  function automatic void model_accept(input logic [NUM_LANES*8-1:0] data, input bit ctrl, input int mode);
    logic [W-1:0]     e;
    logic [127:0]     pay;
    logic [SYM_W-1:0] word;
    if (part_len > 0 && mode != part_mode) model_abort();
    if (part_len == 0) begin
      part_mode = mode;
      part_ctrl = ctrl;
    end
    for (int k = 0; k < NUM_LANES; k++) part_bytes[k][part_len] = data[8*k +: 8];
    part_len++;
    if (part_len == sym_len_of(mode)) begin
      e = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        pay = '0;
        for (int i = 0; i < part_len; i++) pay = pay | (128'(part_bytes[k][i]) << (8*i));
        if (mode == 2)
          word = (SYM_W'(pay[63:0]) << 2) | SYM_W'(part_ctrl ? 2'b10 : 2'b01);
        else if (mode == 1)
          word = (SYM_W'(pay) << 4) | SYM_W'(part_ctrl ? 4'b1010 : 4'b0101);
        else
          word = SYM_W'(pay[7:0]);
        e[SYM_W*k +: SYM_W] = word;
      end
      e[DW +: 2] = 2'(mode);
      e[DW+2]    = (mode != 0) && part_ctrl;
      exp_q.push_back(e);
      part_len = 0;
    end
  endfunction

  // Driver tasks. They are entered and left at posedge + 1.
  task automatic send_byte(input logic [NUM_LANES*8-1:0] data, input bit ctrl, input logic [1:0] mode);
    bit done = 0;
    gen_speed = mode;
    in_data   = data;
    in_ctrl   = ctrl;
    in_valid  = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge enc_clk);
      if (in_ready) done = 1;
      @(posedge enc_clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout actual=stalled required=accepted");
    end else begin
      model_accept(data, ctrl, int'(mode));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge enc_clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < 500) begin
      @(posedge enc_clk);
      #1;
      c++;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL %s_drain actual=%0d pending required=0", name, exp_q.size());
    end
  endtask

  // Random consumer backpressure
  initial begin
    forever begin
      @(posedge enc_clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Scoreboard monitor: compare every handoff against the expected queue
  initial begin
    forever begin
      @(negedge enc_clk);
      if (sym_abort) seen_aborts++;
      if (rst && enable && out_valid && out_ready) begin
        mon_got = {out_ctrl, out_mode, out_data};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_symbol actual=%0h required=none", mon_got);
        end else begin
          check("symbol", mon_got, exp_q.pop_front());
        end
        check("sym_cnt", W'(sym_cnt), W'(exp_sym_cnt[15:0]));
        exp_sym_cnt++;
      end
    end
  end

  // Stimulus sequence
  initial begin
    rst = 1'b0; enable = 1'b1; gen_speed = 2'd2; in_valid = 1'b0;
    in_data = '0; in_ctrl = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_in_ready",  W'(in_ready),  W'(0));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_data",  W'(out_data),  W'(0));
    check("rst_misc",      W'({out_ctrl, out_mode, sym_abort}), W'(0));
    check("rst_sym_cnt",   W'(sym_cnt),   W'(0));
    repeat (2) @(posedge enc_clk);
    #1;
    rst = 1'b1;
    idle(1);

    // Gen2 data symbol with a fixed pattern, plus latency check
    for (int i = 0; i < 8; i++) send_byte(16'(32'h1000 + 32'h0101*i), 1'b0, 2'd2);
    @(negedge enc_clk);
    check("t1_valid_before", W'(out_valid), W'(0));
    @(negedge enc_clk);
    check("t1_valid_after", W'(out_valid), W'(1));
    check("t1_lane0", W'(out_data[65:0]), W'({64'h0706050403020100, 2'b01}));
    check("t1_lane1", W'(out_data[SYM_W +: 66]), W'({64'h1716151413121110, 2'b01}));
    @(negedge enc_clk);
    check("t1_sym_cnt", W'(sym_cnt), W'(1));
    idle(1);

    // Gen3 control symbol with a fixed pattern
    for (int i = 0; i < 16; i++)
      send_byte({8'($urandom_range(0, 255)), 8'(8'hA0 + i)}, 1'b1, 2'd1);
    @(negedge enc_clk);
    @(negedge enc_clk);
    check("t2_lane0", W'(out_data[131:0]),
          W'({128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, 4'b1010}));
    check("t2_ctrl_mode", W'({out_ctrl, out_mode}), W'(3'b101));
    idle(1);
    wait_drain("t2");

    // Backpressure: two gen2 symbols queued with the consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      send_byte(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 2'd2);
    @(negedge enc_clk);
    check("t3_in_ready_low", W'(in_ready), W'(0));
    check("t3_out_valid", W'(out_valid), W'(1));
    snap = out_data;
    repeat (3) @(negedge enc_clk);
    check("t3_data_stable", W'(out_data), W'(snap));
    idle(1);
    out_ready = 1'b1;
    wait_drain("t3");

    // Mode change mid-gather aborts the partial symbol
    for (int i = 0; i < 3; i++) send_byte(16'($urandom_range(0, 65535)), 1'b0, 2'd2);
    gen_speed = 2'd1;
    model_abort();
    @(negedge enc_clk);
    check("t4_in_ready_abort", W'(in_ready), W'(0));
    check("t4_abort_pre", W'(sym_abort), W'(0));
    @(negedge enc_clk);
    check("t4_abort_pulse", W'(sym_abort), W'(1));
    @(negedge enc_clk);
    check("t4_abort_end", W'(sym_abort), W'(0));
    check("t4_sym_cnt", W'(sym_cnt), W'(exp_sym_cnt[15:0]));
    idle(1);
    for (int i = 0; i < 16; i++) send_byte(16'($urandom_range(0, 65535)), 1'b0, 2'd1);
    wait_drain("t4");

    // Bypass bytes back-to-back, then the reserved speed
    send_byte({8'h11, 8'h5A}, 1'b1, 2'd0);
    send_byte({8'h22, 8'hC3}, 1'b0, 2'd0);
    @(negedge enc_clk);
    check("t5_first", W'({out_ctrl, out_data[7:0]}), W'({1'b0, 8'h5A}));
    @(negedge enc_clk);
    check("t5_second", W'({out_ctrl, out_data[7:0]}), W'({1'b0, 8'hC3}));
    idle(1);
    gen_speed = 2'd3;
    @(negedge enc_clk);
    check("t5_reserved_ready", W'(in_ready), W'(0));
    idle(1);
    wait_drain("t5");

    // Reserved speed with a partial gen2 symbol aborts it
    for (int i = 0; i < 2; i++) send_byte(16'($urandom_range(0, 65535)), 1'b0, 2'd2);
    gen_speed = 2'd3;
    model_abort();
    idle(3);

    // Enable low while a symbol is held
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(16'($urandom_range(0, 65535)), 1'b0, 2'd2);
    idle(2);
    @(negedge enc_clk);
    check("t6_held", W'(out_valid), W'(1));
    idle(1);
    enable = 1'b0;
    @(negedge enc_clk);
    check("t6_en_in_ready", W'(in_ready), W'(0));
    idle(1);
    @(negedge enc_clk);
    check("t6_en_valid", W'({out_valid, sym_abort}), W'(0));
    check("t6_en_sym_cnt", W'(sym_cnt), W'(exp_sym_cnt[15:0]));
    idle(1);
    exp_q.delete();
    enable = 1'b1;
    out_ready = 1'b1;
    idle(1);

    // Asynchronous reset mid-gather
    for (int i = 0; i < 3; i++) send_byte(16'($urandom_range(0, 65535)), 1'b0, 2'd2);
    rst = 1'b0;
    #1;
    check("t6_rst_ready_valid", W'({in_ready, out_valid, sym_abort}), W'(0));
    check("t6_rst_data", W'({out_ctrl, out_mode, out_data}), W'(0));
    check("t6_rst_sym_cnt", W'(sym_cnt), W'(0));
    part_len = 0;
    exp_sym_cnt = 0;
    exp_q.delete();
    idle(1);
    rst = 1'b1;
    idle(1);

    // Randomized traffic with random backpressure and mode switches
    rand_ready = 1;
    gen_speed = 2'd2;
    for (int n = 0; n < 400; n++) begin
      logic [1:0] m;
      m = gen_speed;
      if ($urandom_range(0, 19) == 0) m = 2'($urandom_range(0, 2));
      send_byte(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), m);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
    end
    rand_ready = 0;
    @(posedge enc_clk);
    #2;
    out_ready = 1'b1;
    // Close any partial gather by switching to bypass, which the model mirrors.
    gen_speed = 2'd0;
    model_abort();
    idle(3);
    wait_drain("random");

    check("abort_count", W'(seen_aborts), W'(exp_aborts));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
